branch_predictor_btb: RTL
=========================

// Module: branch_predictor_btb
// PURPOSE
//  Parametrised branch target buffer with per-entry saturating counters.
//  IF side: same-cycle lookup of pc_IF gives predicted next PC, replacing static not-taken fetch.
//  EX side: checks the resolved branch/jump against the prediction carried down the pipeline.
//  EX side then drives mispredict/redirect to IF and hazard logic, updates the table, and keeps stats counters.
// PARAMETERS
//  XLEN      32  address/data width
//  ENTRIES   16  table depth, power of 2, >=2; IDX=log2(ENTRIES)
//  CTR_BITS  2   saturating counter width, >=1
//  STAT_W    32  width of statistics counters
//  PRED_EN   1   0: pred_taken_IF forced 0 (static not-taken); table still updates
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     asynchronous reset, active high
//  pc_IF          in   XLEN  fetch PC
//  pred_taken_IF  out  1     prediction: taken
//  pred_pc_IF     out  XLEN  predicted next PC
//  ex_valid       in   1     EX holds a real instruction (0 for bubble/flushed)
//  ex_is_ctrl     in   1     EX instruction is branch/jal/jalr
//  ex_is_jump     in   1     EX instruction is jal/jalr (unconditional)
//  pc_EX          in   XLEN  PC of EX instruction
//  ex_taken       in   1     resolved direction (1 for jumps)
//  ex_target      in   XLEN  resolved target
//  pred_taken_EX  in   1     pred_taken_IF carried through IF_ID/ID_EX
//  pred_pc_EX     in   XLEN  pred_pc_IF carried through IF_ID/ID_EX
//  mispredict_EX  out  1     redirect fetch, flush IF_ID and ID_EX
//  redirect_pc_EX out  XLEN  correct next PC
//  ctrl_cnt       out  STAT_W resolved control instructions
//  mispred_cnt    out  STAT_W mispredictions
// BEHAVIOUR
//  - Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
//  - Entry: valid, tag, target[XLEN-1:2], ctr[CTR_BITS-1:0].
//  - Lookup is combinational and has no register stage.
//  - hit = valid && tag match.
//  - pred_taken_IF = PRED_EN && hit && ctr[MSB].
//  - pred_pc_IF = pred_taken_IF ? {target,2'b00} : pc_IF+4, mod 2^XLEN.
//  - Mispredict is combinational and valid only when ex_valid is high:
//    actual_npc = ex_taken ? ex_target : pc_EX+4.
//    mispredict_EX = ex_valid && (ex_taken!=pred_taken_EX || (ex_taken && ex_target!=pred_pc_EX)).
//    ex_valid=0 forces mispredict_EX=0.
//  - redirect_pc_EX = actual_npc in all cases, even when mispredict_EX=0.
//  - Update happens at posedge only when ex_valid && ex_is_ctrl, at index/tag of pc_EX:
//    jump: entry <= {1, tag, ex_target, ctr=all-ones}.
//    hit, branch taken: ctr++ saturating at all-ones; target <= ex_target.
//    hit, branch not taken: ctr-- saturating at 0; target unchanged.
//    miss, branch taken: allocate {1, tag, ex_target, ctr=WT}.
//    miss, branch not taken: no change.
//    Miss allocation replaces any valid entry at that index (direct mapped).
//  - WT = 1<<(CTR_BITS-1) (weakly taken); WNT = WT-1.
//  - If lookup and update hit the same index in one cycle, the lookup sees the pre-update entry (no bypass).
//  - Stats: ctrl_cnt increments when ex_valid && ex_is_ctrl.
//  - mispred_cnt increments when mispredict_EX is high.
//  - Both stats counters saturate at 2^STAT_W-1.
//  - Reset (asynchronous, any cycle, including mid-update):
//    all valid=0, ctr=WNT, stats=0.
//    Outputs immediately: pred_taken_IF=0, pred_pc_IF=pc_IF+4.
//    First update edge happens after rst deasserts.
//  - A non-control instruction with pred_taken_EX=1 mispredicts (redirect pc_EX+4) and causes no table update.
// TESTING
//  1 Reset: rst=1, pc_IF=0x100 -> pred_taken_IF=0, pred_pc_IF=0x104, ctrl_cnt=mispred_cnt=0.
//  2 Allocate: branch at 0x40 taken to 0x10, pred_taken_EX=0 -> mispredict=1, redirect 0x10.
//    Next cycle pc_IF=0x40 -> pred_taken=1, pred_pc=0x10.
//  3 Hysteresis: from case 2, one not-taken (ctr WT->WNT) -> pc_IF=0x40 predicts 0x44.
//    Two takens -> ctr=3; one not-taken -> still predicts 0x10.
//  4 Alias, ENTRIES=16: jal at 0x40 then jal at 0x80 (same index).
//    pc_IF=0x40 -> miss, pred_pc=0x44; pc_IF=0x80 -> hit.
//  5 Same-cycle lookup and update of 0x40 with cold table -> pred_taken_IF=0 that cycle, 1 the next.
//  6 PRED_EN=0: loop branch taken 10x -> pred_taken_IF always 0.
//    mispred_cnt=10, ctrl_cnt=10; ex_valid=0 pulses with ex_is_ctrl=1 -> no count change.

Source files
------------

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb
// Description : Direct-mapped branch target buffer with saturating counters;
//               combinational IF-side lookup, EX-side resolve/update/stats.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int STAT_W   = 32,
    parameter int PRED_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_IF,
    output logic              pred_taken_IF,
    output logic [XLEN-1:0]   pred_pc_IF,
    input  logic              ex_valid,
    input  logic              ex_is_ctrl,
    input  logic              ex_is_jump,
    input  logic [XLEN-1:0]   pc_EX,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              pred_taken_EX,
    input  logic [XLEN-1:0]   pred_pc_EX,
    output logic              mispredict_EX,
    output logic [XLEN-1:0]   redirect_pc_EX,
    output logic [STAT_W-1:0] ctrl_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int c_IDX   = $clog2(ENTRIES);
    localparam int c_TAG_W = XLEN - c_IDX - 2;
    localparam logic [CTR_BITS-1:0] c_WT       = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] c_WNT      = c_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;
    localparam logic [STAT_W-1:0]   c_STAT_MAX = '1;

    logic                r_valid  [ENTRIES];
    logic [c_TAG_W-1:0]  r_tag    [ENTRIES];
    logic [XLEN-3:0]     r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [STAT_W-1:0]   r_ctrl_cnt;
    logic [STAT_W-1:0]   r_mispred_cnt;

    logic [c_IDX-1:0]    w_if_idx;
    logic [c_TAG_W-1:0]  w_if_tag;
    logic                w_if_hit;
    logic [c_IDX-1:0]    w_ex_idx;
    logic [c_TAG_W-1:0]  w_ex_tag;
    logic                w_ex_hit;
    logic                w_update;

    // IF-side lookup reads the table as it stands; an update in the same
    // cycle only becomes visible after the clock edge.
    assign w_if_idx      = pc_IF[c_IDX+1:2];
    assign w_if_tag      = pc_IF[XLEN-1:c_IDX+2];
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken_IF = (PRED_EN != 0) && !rst && w_if_hit && r_ctr[w_if_idx][CTR_BITS-1];
    assign pred_pc_IF    = pred_taken_IF ? {r_target[w_if_idx], 2'b00} : pc_IF + XLEN'(4);

    assign redirect_pc_EX = ex_taken ? ex_target : pc_EX + XLEN'(4);
    assign mispredict_EX  = ex_valid &&
                            ((ex_taken != pred_taken_EX) || (ex_taken && (ex_target != pred_pc_EX)));

    assign w_ex_idx = pc_EX[c_IDX+1:2];
    assign w_ex_tag = pc_EX[XLEN-1:c_IDX+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_update = ex_valid && ex_is_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_WNT;
            end
        end else if (w_update) begin
            if (ex_is_jump) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target[XLEN-1:2];
                r_ctr[w_ex_idx]    <= c_CTR_MAX;
            end else if (w_ex_hit) begin
                if (ex_taken) begin
                    r_target[w_ex_idx] <= ex_target[XLEN-1:2];
                    if (r_ctr[w_ex_idx] != c_CTR_MAX)
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + CTR_BITS'(1);
                end else if (r_ctr[w_ex_idx] != '0) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - CTR_BITS'(1);
                end
            end else if (ex_taken) begin
                // Direct mapped: a taken miss evicts whatever lives at this index.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target[XLEN-1:2];
                r_ctr[w_ex_idx]    <= c_WT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_cnt    <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_update && (r_ctrl_cnt != c_STAT_MAX))
                r_ctrl_cnt <= r_ctrl_cnt + STAT_W'(1);
            if (mispredict_EX && (r_mispred_cnt != c_STAT_MAX))
                r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
        end
    end

    assign ctrl_cnt    = r_ctrl_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
